// File: rtl/armleocpu_axi_store_buffer.sv
// ---------------------------------------------------------------------------
// armleocpu_axi_store_buffer
//
// Posted-write buffer between the cache store path and the AXI4 AW/W/B
// channels. Single-word stores are accepted in one cycle into a circular
// queue. They are drained in order as single-beat INCR writes, with only one
// write outstanding at a time.
//
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where valid and ready are both high. A source never drops valid, and
// never changes the payload, until that transfer has happened.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-high reset
//   req_*                 store request channel (valid/ready, addr, data,
//                         strb, prot)
//   empty                 nothing queued and no transaction in flight
//   lookup_addr/_hit      word-address hazard check against every pending
//                         store, including the one in flight
//   err/err_clear         sticky non-OKAY B response flag and its clear
//   axi_aw*/axi_w*/axi_b* AXI4 write channels toward memory
//   dbg_state             current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
// ---------------------------------------------------------------------------
module armleocpu_axi_store_buffer #(
  parameter int ADDR_WIDTH = 34,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [3:0]            req_strb,
  input  logic [2:0]            req_prot,

  output logic                  empty,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic                  err,
  input  logic                  err_clear,

  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic                  axi_awlock,
  output logic [2:0]            axi_awprot,

  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  axi_wlast,

  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,

  output logic [1:0]            dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               err_q, err_d;

  // Queue storage. Only the word address is kept: AXI sees [1:0] forced to
  // zero and the hazard check compares word addresses.
  logic [WA_W-1:0]    addr_mem [DEPTH];
  logic [31:0]        data_mem [DEPTH];
  logic [3:0]         strb_mem [DEPTH];
  logic [2:0]         prot_mem [DEPTH];

  logic push, pop, aw_hs, w_hs;

  // Byte offsets inside a word do not matter for either path.
  logic unused_ok;
  assign unused_ok = ^{req_addr[1:0], lookup_addr[1:0]};

  // Full is judged from the registered count only, so a pop in the same
  // cycle does not let a new store in; this keeps req_ready off the B path.
  assign req_ready = (count_q != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == ST_RESP) && axi_bvalid;
  assign aw_hs     = axi_awvalid && axi_awready;
  assign w_hs      = axi_wvalid && axi_wready;
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

  // FSM next state and channel valids.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // AW and W are independent; each is offered until its own handshake.
        axi_awvalid = !aw_done_q;
        axi_wvalid  = !w_done_q;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = ST_RESP;
      end
      ST_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (count_d != '0) ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Error set takes priority over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (pop && (axi_bresp != 2'b00)) err_d = 1'b1;
    else if (err_clear)              err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Payload storage needs no reset: validity comes from count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= req_addr[ADDR_WIDTH-1:2];
      data_mem[wr_ptr_q] <= req_data;
      strb_mem[wr_ptr_q] <= req_strb;
      prot_mem[wr_ptr_q] <= req_prot;
    end
  end

  // Hazard lookup: entry i is live when its distance from the head is
  // below the registered count (the in-flight head is at distance 0).
  always_comb begin
    logic [PTR_W-1:0] off;
    off        = '0;
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(off) < count_q) &&
          (addr_mem[i] == lookup_addr[ADDR_WIDTH-1:2]))
        lookup_hit = 1'b1;
    end
  end

  assign axi_awaddr  = {addr_mem[rd_ptr_q], 2'b00};
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 1'b0;
  assign axi_awprot  = prot_mem[rd_ptr_q];
  assign axi_wdata   = data_mem[rd_ptr_q];
  assign axi_wstrb   = strb_mem[rd_ptr_q];
  assign axi_wlast   = 1'b1;

  assign empty     = (count_q == '0) && (state_q == ST_IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_armleocpu_axi_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_armleocpu_axi_store_buffer
//
// Directed bench. All stimulus is applied at the falling edge; tick() plays
// the AXI slave for one cycle, records handshakes that occur on the next
// rising edge, updates a small word memory, and returns at the next falling
// edge where the caller inspects the DUT.
// ---------------------------------------------------------------------------
module tb_armleocpu_axi_store_buffer;

  localparam int AW    = 34;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [3:0]    req_strb;
  logic [2:0]    req_prot;
  logic          empty;
  logic [AW-1:0] lookup_addr;
  logic          lookup_hit;
  logic          err, err_clear;
  logic          axi_awvalid, axi_awready;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [2:0]    axi_awsize;
  logic [1:0]    axi_awburst;
  logic          axi_awlock;
  logic [2:0]    axi_awprot;
  logic          axi_wvalid, axi_wready;
  logic [31:0]   axi_wdata;
  logic [3:0]    axi_wstrb;
  logic          axi_wlast;
  logic          axi_bvalid, axi_bready;
  logic [1:0]    axi_bresp;
  logic [1:0]    dbg_state;

  armleocpu_axi_store_buffer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_strb(req_strb), .req_prot(req_prot),
    .empty(empty), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .err(err), .err_clear(err_clear),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] exp_q[$];    // expected AW addresses, in order
  logic [35:0]   exp_w_q[$];  // expected {strb, data}, in order

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // ---------------- slave model state ----------------
  bit            aw_rdy_en, w_rdy_en, b_en;
  int            err_b_idx;
  int            aw_cnt, w_cnt, b_cnt;
  bit            aw_got, w_got;
  logic [AW-1:0] cur_addr;
  logic [35:0]   cur_w;
  bit            pushed_last, b_last, rdy_at_b;
  logic [31:0]   mem [0:255];

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic aw_hs, w_hs, b_hs, push_hs;
    axi_awready = aw_rdy_en;
    axi_wready  = w_rdy_en;
    axi_bvalid  = b_en && aw_got && w_got;
    axi_bresp   = (b_cnt == err_b_idx) ? 2'b10 : 2'b00;
    #1;
    aw_hs   = axi_awvalid && axi_awready;
    w_hs    = axi_wvalid && axi_wready;
    b_hs    = axi_bvalid && axi_bready;
    push_hs = req_valid && req_ready;
    if (axi_bready) check("bready_after_aw_w", {63'd0, aw_got && w_got}, 64'd1);
    if (aw_hs) begin
      check("single_aw", {63'd0, aw_got}, 64'd0);
      if (exp_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
      else check("aw_addr", {30'd0, axi_awaddr}, {30'd0, exp_q.pop_front()});
      cur_addr = axi_awaddr;
    end
    if (w_hs) begin
      check("single_w", {63'd0, w_got}, 64'd0);
      if (exp_w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
      else check("w_strb_data", {28'd0, axi_wstrb, axi_wdata},
                 {28'd0, exp_w_q.pop_front()});
      cur_w = {axi_wstrb, axi_wdata};
    end
    if (push_hs) begin
      exp_q.push_back({req_addr[AW-1:2], 2'b00});
      exp_w_q.push_back({req_strb, req_data});
    end
    rdy_at_b = b_hs ? req_ready : rdy_at_b;
    @(posedge clk);
    pushed_last = push_hs;
    b_last      = b_hs;
    if (aw_hs) begin aw_got = 1'b1; aw_cnt++; end
    if (w_hs)  begin w_got  = 1'b1; w_cnt++;  end
    if (b_hs) begin
      if (axi_bresp == 2'b00)
        for (int b = 0; b < 4; b++)
          if (cur_w[32+b]) mem[cur_addr[9:2]][8*b +: 8] = cur_w[8*b +: 8];
      aw_got = 1'b0;
      w_got  = 1'b0;
      b_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    bit done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_strb  = s;
    req_prot  = p;
    for (int k = 0; k < 50 && !done; k++) begin
      tick();
      done = pushed_last;
    end
    req_valid = 1'b0;
    if (!done) check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_empty(input int max_cycles);
    int k;
    k = 0;
    while (!empty && k < max_cycles) begin
      tick();
      k++;
    end
    check("drain_empty", {63'd0, empty}, 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, {63'd0, req_ready},   64'd1);
    check({tag, "_empty"},     {63'd0, empty},       64'd1);
    check({tag, "_awvalid"},   {63'd0, axi_awvalid}, 64'd0);
    check({tag, "_wvalid"},    {63'd0, axi_wvalid},  64'd0);
    check({tag, "_bready"},    {63'd0, axi_bready},  64'd0);
    check({tag, "_err"},       {63'd0, err},         64'd0);
    check({tag, "_state"},     {62'd0, dbg_state},   64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int base, k;
    bit first;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst_n = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_strb = '0;
    req_prot = '0; lookup_addr = '0; err_clear = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    axi_bresp = 2'b00;
    aw_rdy_en = 1'b1; w_rdy_en = 1'b1; b_en = 1'b1; err_b_idx = -1;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_got = 1'b0; w_got = 1'b0;
    cur_addr = '0; cur_w = '0; pushed_last = 1'b0; b_last = 1'b0;
    rdy_at_b = 1'b0;
    @(negedge clk);
    tick(); tick();
    check_idle_outputs("reset");
    check("reset_lookup", {63'd0, lookup_hit}, 64'd0);
    rst_n = 1'b0;
    tick();

    // ---- single store ----
    push(34'h4, 32'hFF00FF00, 4'hF, 3'b010);
    check("t1_awvalid_push_cycle", {63'd0, axi_awvalid}, 64'd0);
    check("t1_not_empty", {63'd0, empty}, 64'd0);
    tick();
    check("t1_awvalid_next", {63'd0, axi_awvalid}, 64'd1);
    check("t1_wvalid_next", {63'd0, axi_wvalid}, 64'd1);
    check("t1_awaddr", {30'd0, axi_awaddr}, 64'h4);
    check("t1_awlen", {56'd0, axi_awlen}, 64'd0);
    check("t1_awsize", {61'd0, axi_awsize}, 64'd2);
    check("t1_awburst", {62'd0, axi_awburst}, 64'd1);
    check("t1_awlock", {63'd0, axi_awlock}, 64'd0);
    check("t1_awprot", {61'd0, axi_awprot}, 64'd2);
    check("t1_wlast", {63'd0, axi_wlast}, 64'd1);
    wait_empty(20);
    check("t1_mem", {32'd0, mem[1]}, 64'hFF00FF00);

    // ---- fill with AW blocked, then drain in order ----
    aw_rdy_en = 1'b0;
    base = b_cnt;
    for (int i = 0; i < 4; i++)
      push(34'h10 + 34'(4*i), 32'hA0A0_0000 + 32'(i), 4'hF, 3'b000);
    check("t2_full_not_ready", {63'd0, req_ready}, 64'd0);
    req_valid = 1'b1; req_addr = 34'h20; req_data = 32'hDEAD_BEEF;
    req_strb = 4'hF;
    tick();
    check("t2_stall_no_accept", {63'd0, pushed_last}, 64'd0);
    req_valid = 1'b0;
    tick(); tick();
    check("t2_queue_depth", 64'(exp_q.size()), 64'd4);
    aw_rdy_en = 1'b1;
    first = 1'b1;
    k = 0;
    while (!(empty && b_cnt - base == 4) && k < 60) begin
      tick();
      if (b_last && first) begin
        check("t2_ready_low_at_pop", {63'd0, rdy_at_b}, 64'd0);
        check("t2_ready_after_pop", {63'd0, req_ready}, 64'd1);
        first = 1'b0;
      end
      k++;
    end
    check("t2_b_count", 64'(b_cnt - base), 64'd4);
    check("t2_empty", {63'd0, empty}, 64'd1);
    check("t2_mem_0x10", {32'd0, mem[4]}, 64'hA0A0_0000);
    check("t2_mem_0x1c", {32'd0, mem[7]}, 64'hA0A0_0003);

    // ---- AW three cycles before W ----
    aw_rdy_en = 1'b1; w_rdy_en = 1'b0;
    base = aw_cnt;
    push(34'h40, 32'h1122_3344, 4'hF, 3'b000);
    k = 0;
    while (aw_cnt == base && k < 10) begin tick(); k++; end
    check("t3_aw_seen", 64'(aw_cnt - base), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("t3_awvalid_dropped", {63'd0, axi_awvalid}, 64'd0);
      check("t3_wvalid_held", {63'd0, axi_wvalid}, 64'd1);
      check("t3_no_bready", {63'd0, axi_bready}, 64'd0);
      tick();
    end
    w_rdy_en = 1'b1;
    base = w_cnt;
    wait_empty(20);
    check("t3_one_w", 64'(w_cnt - base), 64'd1);
    check("t3_mem", {32'd0, mem[16]}, 64'h1122_3344);

    // ---- W three cycles before AW ----
    aw_rdy_en = 1'b0; w_rdy_en = 1'b1;
    base = w_cnt;
    push(34'h44, 32'h5566_7788, 4'hF, 3'b000);
    k = 0;
    while (w_cnt == base && k < 10) begin tick(); k++; end
    check("t3r_w_seen", 64'(w_cnt - base), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("t3r_wvalid_dropped", {63'd0, axi_wvalid}, 64'd0);
      check("t3r_awvalid_held", {63'd0, axi_awvalid}, 64'd1);
      check("t3r_no_bready", {63'd0, axi_bready}, 64'd0);
      tick();
    end
    aw_rdy_en = 1'b1;
    base = aw_cnt;
    wait_empty(20);
    check("t3r_one_aw", 64'(aw_cnt - base), 64'd1);
    check("t3r_mem", {32'd0, mem[17]}, 64'h5566_7788);

    // ---- hazard lookup ----
    aw_rdy_en = 1'b0; w_rdy_en = 1'b0;
    push(34'h100, 32'hCAFE_BABE, 4'b0011, 3'b000);
    lookup_addr = 34'h102; #1;
    check("t4_hit_0x102", {63'd0, lookup_hit}, 64'd1);
    lookup_addr = 34'h104; #1;
    check("t4_miss_0x104", {63'd0, lookup_hit}, 64'd0);
    lookup_addr = 34'h200;
    req_valid = 1'b1; req_addr = 34'h200; req_data = 32'h0000_1234;
    req_strb = 4'hF; #1;
    check("t4_push_invisible", {63'd0, lookup_hit}, 64'd0);
    tick();
    req_valid = 1'b0; #1;
    check("t4_pushed_visible", {63'd0, lookup_hit}, 64'd1);
    lookup_addr = 34'h102; #1;
    check("t4_inflight_hit", {63'd0, lookup_hit}, 64'd1);
    aw_rdy_en = 1'b1; w_rdy_en = 1'b1;
    wait_empty(30);
    #1;
    check("t4_miss_after_b", {63'd0, lookup_hit}, 64'd0);
    check("t4_mem_strb", {32'd0, mem[64]}, 64'h0000_BABE);
    check("t4_mem_0x200", {32'd0, mem[128]}, 64'h0000_1234);
    lookup_addr = 34'h0;

    // ---- error on the 2nd of 3 stores ----
    err_b_idx = b_cnt + 1;
    push(34'h300, 32'h0000_0001, 4'hF, 3'b000);
    push(34'h304, 32'h0000_0002, 4'hF, 3'b000);
    push(34'h308, 32'h0000_0003, 4'hF, 3'b000);
    wait_empty(40);
    err_b_idx = -1;
    check("t5_err_set", {63'd0, err}, 64'd1);
    check("t5_third_written", {32'd0, mem[194]}, 64'h3);
    tick();
    check("t5_err_sticky", {63'd0, err}, 64'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t5_err_cleared", {63'd0, err}, 64'd0);

    // ---- error and clear in the same cycle ----
    err_b_idx = b_cnt;
    err_clear = 1'b1;
    push(34'h30C, 32'h0000_0004, 4'hF, 3'b000);
    k = 0;
    b_last = 1'b0;
    while (!b_last && k < 20) begin tick(); k++; end
    check("t5_set_wins", {63'd0, err}, 64'd1);
    tick();
    check("t5_clear_after", {63'd0, err}, 64'd0);
    err_clear = 1'b0;
    err_b_idx = -1;

    // ---- reset while in RESP with two entries ----
    err_b_idx = b_cnt;
    push(34'h3F0, 32'h0000_0005, 4'hF, 3'b000);
    wait_empty(20);
    err_b_idx = -1;
    check("t6_err_before", {63'd0, err}, 64'd1);
    b_en = 1'b0;
    push(34'h400, 32'h0000_0006, 4'hF, 3'b000);
    push(34'h404, 32'h0000_0007, 4'hF, 3'b000);
    k = 0;
    while (dbg_state != 2'd2 && k < 20) begin tick(); k++; end
    check("t6_in_resp", {62'd0, dbg_state}, 64'd2);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("t6_async");
    lookup_addr = 34'h404; #1;
    check("t6_lookup_cleared", {63'd0, lookup_hit}, 64'd0);
    exp_q.delete();
    exp_w_q.delete();
    aw_got = 1'b0; w_got = 1'b0;
    tick();
    check_idle_outputs("t6_next");
    rst_n = 1'b0;
    b_en = 1'b1;
    lookup_addr = 34'h0;
    tick();
    push(34'h0C0, 32'h7777_8888, 4'hF, 3'b000);
    wait_empty(20);
    check("t6_post_reset_mem", {32'd0, mem[48]}, 64'h7777_8888);
    check("final_aw_q", 64'(exp_q.size()), 64'd0);
    check("final_w_q", 64'(exp_w_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/armleocpu_axi_store_buffer.md
Name: armleocpu_axi_store_buffer

Overview:
Posted-write buffer between the cache store path and the AXI4 write channels (AW/W/B), in front of the memory (e.g. armleocpu_axi_bram). Accepts single-word store requests in one cycle and queues them in order. Drains them as single-beat AXI4 writes, one outstanding at a time. Exposes empty, address-hazard lookup and sticky error outputs so the cache can order loads, flushes and fences against pending stores.

Parameters:
ADDR_WIDTH, 34, AXI address width; request address width.
DEPTH, 4, queue entries; power of two, >= 2.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset; asynchronous, active-high.
req_valid  input  1  store request valid.
req_ready  output  1  buffer can accept a request.
req_addr  input  ADDR_WIDTH  store byte address.
req_data  input  32  store data, lane-aligned.
req_strb  input  4  byte enables.
req_prot  input  3  AXI prot for this store.
empty  output  1  no entries queued and no transaction in flight.
lookup_addr  input  ADDR_WIDTH  load address to check.
lookup_hit  output  1  some queued or in-flight entry matches lookup_addr[ADDR_WIDTH-1:2].
err  output  1  sticky: a B response other than OKAY was received.
err_clear  input  1  clears err.
axi_awvalid  output  1  AW valid.
axi_awready  input  1  AW ready.
axi_awaddr  output  ADDR_WIDTH  head address with [1:0] forced to 0.
axi_awlen  output  8  constant 0.
axi_awsize  output  3  constant 3'b010.
axi_awburst  output  2  constant 2'b01 (INCR).
axi_awlock  output  1  constant 0.
axi_awprot  output  3  head req_prot.
axi_wvalid  output  1  W valid.
axi_wready  input  1  W ready.
axi_wdata  output  32  head data.
axi_wstrb  output  4  head strobes.
axi_wlast  output  1  constant 1.
axi_bvalid  input  1  B valid.
axi_bready  output  1  B ready.
axi_bresp  input  2  B response.

Behaviour:
- Reset (rst_n high): count=0, rd/wr pointers 0, state IDLE, aw_done=w_done=0, err=0. Outputs: req_ready=1, empty=1, lookup_hit=0, awvalid=wvalid=bready=0.
- Queue: circular, DEPTH entries of {addr, data, strb, prot}. Count is clog2(DEPTH)+1 bits.
- req_ready = (count != DEPTH). Registered-count based: a same-cycle pop does not raise req_ready.
- Push when req_valid&&req_ready: entry written at wr_ptr; wr_ptr wraps modulo DEPTH. Push and pop in the same cycle leaves count unchanged.
- FSM:
  - IDLE: if count!=0, go to ISSUE next cycle. awvalid and wvalid both assert in ISSUE (1-cycle latency from first push into an empty buffer to awvalid).
  - ISSUE: awvalid=!aw_done, wvalid=!w_done. Each handshake sets its done flag. AW and W may complete in either order or in the same cycle. When both are complete (flags or current handshakes), go to RESP.
  - RESP: bready=1. On bvalid: pop head (rd_ptr++, count--), clear done flags, set err if bresp!=2'b00. Then go to ISSUE if count after pop !=0, else IDLE.
- Head entry (outputs) is stable from ISSUE entry until pop. Valids never drop before their handshake.
- At most one AW outstanding; stores complete to memory in acceptance order.
- empty = (count==0) && state==IDLE.
- lookup_hit: combinational OR over all valid entries, including the in-flight head, of addr[ADDR_WIDTH-1:2]==lookup_addr[ADDR_WIDTH-1:2]. An entry being pushed this cycle is not visible.
- err: set by an error B response. err_clear clears it. If set and clear occur in the same cycle, set wins.
- The entry is popped regardless of bresp; no retry.
- Reset mid-transaction: all state is cleared immediately and queued stores are discarded. The downstream is reset by the same rst_n.

Test Plan:
- Single store addr=0x0000_0004, data=0xFF00FF00, strb=4'hF; AW/W ready=1, bresp=0 next cycle -> awaddr=0x4, awlen=0, wlast=1; awvalid rises 1 cycle after push; empty returns 1 after B; memory reads 0xFF00FF00.
- Fill DEPTH=4 with awready held 0 -> req_ready=0 after 4th push; 5th request stalls. Release awready -> writes issue in order 0x10,0x14,0x18,0x1C; one pop per B; req_ready reasserts the cycle after the first pop.
- AW accepted 3 cycles before W, then the reverse order -> exactly one AW and one W handshake per entry; bready only after both complete.
- Queue holds 0x100 (strb 4'b0011) -> lookup_addr 0x102 gives hit=1; 0x104 gives 0. After its B, 0x102 gives 0.
- bresp=2'b10 on the 2nd of 3 stores -> err=1 stays set, the 3rd store still issues, err_clear drops err. Same-cycle error and clear -> err=1.
- Assert rst_n while in RESP with 2 entries queued -> next cycle count=0, empty=1, awvalid=wvalid=bready=0, err=0.
